// File: rtl/gfmpw_rejunity_snn_pkg.sv
// Shared sizes, config field offsets and saturation helper for the 3-input, 4-neuron LIF SNN.
// Pure constants/functions: no latency, no flow control.
package gfmpw_snn_pkg;

  localparam int N_IN      = 3;
  localparam int N_NEU     = 4;
  localparam int W_BITS    = 2;
  localparam int U_BITS    = 8;
  localparam int CFG_BITS  = 32;
  localparam int THR_LSB   = 24;
  localparam int LEAK_LSB  = 28;
  localparam int THR_BITS  = 4;
  localparam int LEAK_BITS = 2;
  // Wide enough for membrane minus decay plus the largest synaptic sum without wrap.
  localparam int ACC_BITS  = 10;

  localparam logic [7:0] UIO_OE = 8'hF0;

  localparam logic signed [ACC_BITS-1:0] U_MAX = 10'sd127;
  localparam logic signed [ACC_BITS-1:0] U_MIN = -10'sd128;

  function automatic logic [U_BITS-1:0] sat_u(input logic signed [ACC_BITS-1:0] v);
    logic [U_BITS-1:0] r;
    if (v > U_MAX) r = 8'h7F;
    else if (v < U_MIN) r = 8'h80;
    else r = v[U_BITS-1:0];
    return r;
  endfunction

endpackage

// File: rtl/gfmpw_rejunity_snn_if.sv
// Pad-side bundle of the SNN: user IO, logic-analyser readback and interrupts.
// Wires only; master drives uio_in, slave drives everything else.
interface gfmpw_rejunity_snn_if;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [63:0] la_data_out;
  logic [2:0]  irq;

  modport master (output uio_in, input uio_out, uio_oe, la_data_out, irq);
  modport slave  (input uio_in, output uio_out, uio_oe, la_data_out, irq);
endinterface

// File: rtl/gfmpw_rejunity_snn_lif_neuron.sv
// One leaky integrate-and-fire neuron; spike and membrane registered, one-cycle latency.
// No flow control: updates every clock unless clear forces membrane and spike to zero.
module snn_lif_neuron
  import gfmpw_snn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*W_BITS-1:0]   weights,
  input  logic [N_IN-1:0]          in_spk,
  input  logic [THR_BITS-1:0]      thr,
  input  logic [LEAK_BITS-1:0]     leak,
  input  logic                     clear,
  output logic                     spike,
  output logic [U_BITS-1:0]        membrane
);

  logic signed [ACC_BITS-1:0] u_ext;
  logic signed [ACC_BITS-1:0] decay;
  logic signed [ACC_BITS-1:0] w_ext;
  logic signed [ACC_BITS-1:0] syn_sum;
  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] sat_ext;
  logic signed [ACC_BITS-1:0] thr_lvl;
  logic [U_BITS-1:0]          u_nxt;
  logic                       fire;

  always_comb begin
    u_ext = {{(ACC_BITS-U_BITS){membrane[U_BITS-1]}}, membrane};
    case (leak)
      2'd1:    decay = u_ext >>> 3;
      2'd2:    decay = u_ext >>> 2;
      2'd3:    decay = u_ext >>> 1;
      default: decay = '0;
    endcase

    syn_sum = '0;
    w_ext   = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_ext = {{(ACC_BITS-W_BITS){weights[W_BITS*i+W_BITS-1]}}, weights[W_BITS*i +: W_BITS]};
      if (in_spk[i]) syn_sum = syn_sum + w_ext;
    end

    acc     = u_ext - decay + syn_sum;
    u_nxt   = sat_u(acc);
    sat_ext = {{(ACC_BITS-U_BITS){u_nxt[U_BITS-1]}}, u_nxt};
    // Threshold is exclusive: the stored value fires one above it, so thr=0 fires on >=1.
    thr_lvl = {{(ACC_BITS-THR_BITS){1'b0}}, thr};
    thr_lvl = thr_lvl + 10'sd1;
    fire    = (sat_ext >= thr_lvl);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike    <= 1'b0;
      membrane <= '0;
    end else if (clear) begin
      spike    <= 1'b0;
      membrane <= '0;
    end else if (fire) begin
      spike    <= 1'b1;
      membrane <= '0;
    end else begin
      spike    <= 1'b0;
      membrane <= u_nxt;
    end
  end

endmodule

// File: rtl/gfmpw_rejunity_snn.sv
// SNN top: serial config shift register feeding four LIF neurons; all outputs registered, 1-cycle latency.
// No backpressure: cfg_en=1 shifts config and clears neurons, cfg_en=0 runs one step per clock.
module gfmpw_rejunity_snn
  import gfmpw_snn_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire  vdd,
  inout  wire  vss,
`endif
  input  logic                   wb_clk_i,
  input  logic                   rst_n,
  gfmpw_rejunity_snn_if.slave    bus
);

  logic [CFG_BITS-1:0]            cfg;
  logic [N_NEU-1:0]               spk;
  logic [N_NEU-1:0][U_BITS-1:0]   mem;
  logic                           cfg_en;
  logic                           unused_uio;

  assign cfg_en     = bus.uio_in[3];
  assign unused_uio = ^bus.uio_in[7:4];

  // First bit shifted in lands in cfg[0] after a full 32-bit load.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) cfg <= '0;
    else if (cfg_en) cfg <= {bus.uio_in[0], cfg[CFG_BITS-1:1]};
  end

  for (genvar n = 0; n < N_NEU; n++) begin : g_neu
    snn_lif_neuron u_neuron (
      .clk      (wb_clk_i),
      .rst_n    (rst_n),
      .weights  (cfg[n*N_IN*W_BITS +: N_IN*W_BITS]),
      .in_spk   (bus.uio_in[N_IN-1:0]),
      .thr      (cfg[THR_LSB +: THR_BITS]),
      .leak     (cfg[LEAK_LSB +: LEAK_BITS]),
      .clear    (cfg_en),
      .spike    (spk[n]),
      .membrane (mem[n])
    );
  end

  assign bus.uio_out     = {spk, 4'b0000};
  assign bus.uio_oe      = UIO_OE;
  assign bus.la_data_out = {mem, cfg};
  assign bus.irq         = {1'b0, &spk, |spk};

endmodule

// File: tb/tb_gfmpw_rejunity_snn.sv
// Self-checking bench: directed vector tables, multi-cycle corner sequences and randomized
// traffic compared against an integer-arithmetic model of the LIF network.
module tb_gfmpw_rejunity_snn;

  logic wb_clk_i = 1'b0;
  logic rst_n;

  gfmpw_rejunity_snn_if bus ();

  gfmpw_rejunity_snn dut (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_cfg;
  int          m_u   [4];
  bit          m_spk [4];

  typedef struct {
    logic [7:0] in;
    logic [7:0] uio;
    logic [2:0] irq;
    logic [7:0] mem;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wval(input int n, input int i);
    int k;
    int b;
    k = 3 * n + i;
    b = int'(m_cfg[2*k +: 2]);
    return (b >= 2) ? b - 4 : b;
  endfunction

  task automatic model_reset();
    m_cfg = '0;
    for (int n = 0; n < 4; n++) begin
      m_u[n]   = 0;
      m_spk[n] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] in);
    int sum, leak, thr, decay, nv;
    if (in[3]) begin
      m_cfg = {in[0], m_cfg[31:1]};
      for (int n = 0; n < 4; n++) begin
        m_u[n]   = 0;
        m_spk[n] = 0;
      end
    end else begin
      leak = int'(m_cfg[29:28]);
      thr  = int'(m_cfg[27:24]);
      for (int n = 0; n < 4; n++) begin
        sum = 0;
        for (int i = 0; i < 3; i++) if (in[i]) sum += wval(n, i);
        decay = (leak == 0) ? 0 : (m_u[n] >>> (4 - leak));
        nv = m_u[n] - decay + sum;
        if (nv > 127) nv = 127;
        if (nv < -128) nv = -128;
        if (nv >= thr + 1) begin
          m_spk[n] = 1;
          m_u[n]   = 0;
        end else begin
          m_spk[n] = 0;
          m_u[n]   = nv;
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_la();
    logic [63:0] r;
    logic [31:0] t;
    r[31:0] = m_cfg;
    for (int n = 0; n < 4; n++) begin
      t = m_u[n];
      r[32+8*n +: 8] = t[7:0];
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_uio();
    return {m_spk[3], m_spk[2], m_spk[1], m_spk[0], 4'b0000};
  endfunction

  function automatic logic [2:0] exp_irq();
    logic any_s, all_s;
    any_s = m_spk[0] | m_spk[1] | m_spk[2] | m_spk[3];
    all_s = m_spk[0] & m_spk[1] & m_spk[2] & m_spk[3];
    return {1'b0, all_s, any_s};
  endfunction

  task automatic tick(input logic [7:0] in);
    bus.uio_in = in;
    model_step(in);
    @(posedge wb_clk_i);
    #1;
    check("model_la", bus.la_data_out, exp_la());
    check("model_uio_out", {56'd0, bus.uio_out}, {56'd0, exp_uio()});
    check("model_irq", {61'd0, bus.irq}, {61'd0, exp_irq()});
  endtask

  task automatic shift_cfg(input logic [31:0] w);
    for (int b = 0; b < 32; b++) tick({4'b0000, 1'b1, 2'b00, w[b]});
    check("cfg_load", {32'd0, bus.la_data_out[31:0]}, {32'd0, w});
  endtask

  // Drop reset between edges and confirm outputs clear without waiting for a clock.
  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_la"}, bus.la_data_out, 64'd0);
    check({tag, "_uio"}, {56'd0, bus.uio_out}, 64'd0);
    check({tag, "_irq"}, {61'd0, bus.irq}, 64'd0);
    model_reset();
    @(negedge wb_clk_i);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  rin;
    logic [31:0] rcfg;
    logic [7:0]  exp_m;
    int          v;

    bus.uio_in = 8'h00;
    rst_n      = 1'b0;
    model_reset();
    repeat (2) @(posedge wb_clk_i);
    #1;
    check("rst_la", bus.la_data_out, 64'd0);
    check("rst_uio", {56'd0, bus.uio_out}, 64'd0);
    check("rst_irq", {61'd0, bus.irq}, 64'd0);
    check("uio_oe", {56'd0, bus.uio_oe}, 64'hF0);
    @(negedge wb_clk_i);
    rst_n = 1'b1;

    // Idle after reset: zero weights, threshold 1 -> nothing moves.
    for (int c = 0; c < 10; c++) tick(8'h00);
    check("idle_la", bus.la_data_out, 64'd0);
    check("idle_uio", {56'd0, bus.uio_out}, 64'd0);

    // All weights +1, thr=3: membranes 3 then fire, alternating.
    tbl[0] = '{8'h07, 8'h00, 3'd0, 8'h03};
    tbl[1] = '{8'h07, 8'hF0, 3'd3, 8'h00};
    tbl[2] = '{8'h07, 8'h00, 3'd0, 8'h03};
    tbl[3] = '{8'h07, 8'hF0, 3'd3, 8'h00};
    tbl[4] = '{8'hF7, 8'h00, 3'd0, 8'h03};
    tbl[5] = '{8'h07, 8'hF0, 3'd3, 8'h00};
    shift_cfg(32'h0355_5555);
    for (int i = 0; i < 6; i++) begin
      tick(tbl[i].in);
      check("tbl_uio", {56'd0, bus.uio_out}, {56'd0, tbl[i].uio});
      check("tbl_irq", {61'd0, bus.irq}, {61'd0, tbl[i].irq});
      check("tbl_mem", {32'd0, bus.la_data_out[63:32]}, {32'd0, {4{tbl[i].mem}}});
    end

    // One cfg_en cycle mid-run clears neurons on that edge.
    tick(8'h07);
    check("pre_clear_mem", {32'd0, bus.la_data_out[63:32]}, 64'h0303_0303);
    tick(8'h09);
    check("clear_mem", {32'd0, bus.la_data_out[63:32]}, 64'd0);
    check("clear_uio", {56'd0, bus.uio_out}, 64'd0);
    check("clear_cfg", {32'd0, bus.la_data_out[31:0]}, 64'h81AA_AAAA);
    tick(8'h07);
    async_reset_check("async_rst_a");
    tick(8'h00);
    check("post_rst_la", bus.la_data_out, 64'd0);

    // Leak 1, thr 15, only w(0,0)=+1: ramp to 8 and hold.
    shift_cfg(32'h1F00_0001);
    for (int c = 1; c <= 50; c++) begin
      tick(8'h01);
      v = (c < 8) ? c : 8;
      check("leak_mem0", {56'd0, bus.la_data_out[39:32]}, 64'(v));
      check("leak_uio", {56'd0, bus.uio_out}, 64'd0);
    end

    // All weights -2: fall by 6 per cycle and saturate at -128.
    shift_cfg(32'h00AA_AAAA);
    for (int c = 1; c <= 30; c++) begin
      tick(8'h07);
      v = -6 * c;
      if (v < -128) v = -128;
      exp_m = 8'(v);
      check("neg_mem", {32'd0, bus.la_data_out[63:32]}, {32'd0, {4{exp_m}}});
      check("neg_uio", {56'd0, bus.uio_out}, 64'd0);
      if (c == 22) check("neg_sat_c22", {56'd0, bus.la_data_out[39:32]}, 64'h80);
    end

    // Randomized configurations and traffic, with occasional cfg_en and one mid-run reset.
    for (int r = 0; r < 6; r++) begin
      rcfg = $urandom;
      shift_cfg(rcfg);
      for (int j = 0; j < 150; j++) begin
        rin = 8'($urandom);
        rin[3] = ($urandom_range(0, 19) == 0);
        tick(rin);
        if (r == 3 && j == 75) async_reset_check("async_rst_rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gfmpw_rejunity_snn.md
GFMPW_REJUNITY_SNN -- requirements
Module: gfmpw_rejunity_snn

Interface
REQ-001 SHALL have no parameters; all sizes are fixed constants: N_IN=3, N_NEU=4, W_BITS=2, U_BITS=8, CFG_BITS=32.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 uio_in  input  8  [2:0] input spikes (run mode); [0] serial config data (config mode); [3] cfg_en; [7:4] ignored.
REQ-005 uio_out  output  8  [7:4] registered spikes of neurons 3..0; [3:0] constant 0.
REQ-006 uio_oe  output  8  constant 8'hF0 (1 = output).
REQ-007 la_data_out  output  64  [31:0] config register; [32+8n+7:32+8n] membrane of neuron n, two's complement.
REQ-008 irq  output  3  [0] OR of spike register; [1] AND of spike register; [2] constant 0.
REQ-009 vdd/vss SHALL exist only under USE_POWER_PINS.

Function
REQ-010 Config register cfg[31:0] fields: weight w(n,i) at bits [2k+1:2k] with k=3n+i, signed 2-bit (-2..+1); thr=cfg[27:24]; leak=cfg[29:28]; cfg[31:30] reserved, stored, unused.
REQ-011 Config mode (cfg_en=1): each clock cfg <= {uio_in[0], cfg[31:1]}, so the first bit sent ends in cfg[0] after 32 shifts; every membrane and spike bit is cleared in the same cycle.
REQ-012 Run mode (cfg_en=0): each clock every neuron n updates as REQ-013..REQ-016; cfg holds.
REQ-013 sum(n) = sum over i of (uio_in[i] ? w(n,i) : 0), range -6..+3.
REQ-014 decay = 0 if leak==0, else u >>> (4-leak) (arithmetic shift); leaked = u - decay.
REQ-015 new = leaked + sum computed at 10 bits, saturated to [-128, +127].
REQ-016 new >= thr+1 (signed compare): spike=1 and u <= 0; otherwise spike=0 and u <= new.
REQ-017 Spikes are registered: the response to inputs sampled at edge t appears on uio_out/irq after edge t (one-cycle latency); there are no combinational paths from input to output.
REQ-018 la_data_out and irq reflect register contents only.

Reset
REQ-019 rst_n low SHALL immediately clear cfg, all membranes and all spike bits, forcing uio_out=0, irq=0 and la_data_out=0 regardless of clock.
REQ-020 After reset: all weights 0 and threshold 1, so no neuron spikes until reconfigured.
REQ-021 Reset asserted mid-configuration or mid-run SHALL discard all partial state; operation resumes on the first edge after release.

Structure
REQ-022 Package gfmpw_snn_pkg SHALL hold N_IN, N_NEU, W_BITS, U_BITS, CFG_BITS, the field offsets (thr at 24, leak at 28) and the UIO_OE constant 8'hF0.
REQ-023 Sub-module snn_lif_neuron (weights, inputs, thr, leak, clear -> spike, membrane) SHALL be instantiated N_NEU times; the top holds the config shift register and output mapping.

Verification
REQ-024 Reset then idle 10 cycles with uio_in=0 -> uio_out=0, irq=0, la_data_out=0.
REQ-025 Shift 0x03555555 LSB-first with cfg_en=1 -> la_data_out[31:0]=0x03555555 after 32 clocks. Then run with uio_in=3'b111 -> membranes 3, then spike with membranes 0; uio_out[7:4] alternates 0x0/0xF; irq[1:0] alternates 0/3.
REQ-026 Config 0x1F000001 (leak=1, thr=15, w(0,0)=+1 only), uio_in[0]=1 -> membrane 0 ramps 1..8 and holds at 8; no spike within 50 cycles.
REQ-027 All weights -2 (0x00AAAAAA), uio_in=3'b111 -> each membrane decreases by 6 per cycle, reaches 0x80 on cycle 22 and stays; no spikes.
REQ-028 Mid-run: set cfg_en=1 for 1 cycle -> membranes and spikes are 0 on the next edge. Drop rst_n between edges -> outputs are 0 immediately.
